mult_div_seq: RTL and testbench

- Iterative signed multiply/divide sequencer that owns the HI/LO register pair for the multicycle CPU.
- The control unit pulses Div_Mult_Ctrl as `start`, with A/B register values as operands, then waits on `busy`/`done`.
- On divide-by-zero it raises `div0` instead, which the control unit routes to its DIV0 exception path.
- Shift-add (Booth radix-2) multiply and restoring division on magnitudes, with sign correction.

---
 rtl/md_pkg.sv | 23 ++
 rtl/md_sign_fix.sv | 21 ++
 rtl/mult_div_seq.sv | 204 ++++++++++++++++++++
 tb/tb_mult_div_seq.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - shared definitions for the multiply/divide sequencer
// Purpose: op encodings, FSM state type and iteration count used by
//          mult_div_seq and its testbench.
// Ports:   none (package).
package md_pkg;

  // One Booth or restoring step per cycle for every operand bit.
  localparam int MD_ITER = 32;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_DIV   = 2'b01;
  localparam logic [1:0] MD_MULTU = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MULT    = 3'd1,
    ST_DIV     = 3'd2,
    ST_DIV_FIX = 3'd3,
    ST_DONE    = 3'd4
  } md_state_t;

endpackage

// File: rtl/md_sign_fix.sv
// rtl/md_sign_fix.sv - conditional two's-complement negation of a value pair
// Purpose: turns quotient/remainder magnitudes into signed results, and is
//          also used to take |a| and |b| of the incoming operands.
// Ports:   mag_q, mag_r - unsigned magnitudes in
//          neg_q, neg_r - negate the corresponding magnitude when set
//          q, r         - corrected values out
module md_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] mag_q,
  input  logic [WIDTH-1:0] mag_r,
  input  logic             neg_q,
  input  logic             neg_r,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r
);

  assign q = neg_q ? (-mag_q) : mag_q;
  assign r = neg_r ? (-mag_r) : mag_r;

endmodule

// File: rtl/mult_div_seq.sv
// rtl/mult_div_seq.sv - iterative signed multiply/divide unit owning HI/LO
// Purpose: Booth radix-2 multiply and restoring divide, one step per cycle.
//          Optional unsigned multu/divu support under MULT_DIV_UNSIGNED_EN.
// Ports:   clk, reset_in (async, active-high)
//          start, op, a, b  - request (sampled only when idle)
//          busy             - operation in progress
//          done, div0       - one-cycle completion / divide-by-zero pulses
//          hi, lo           - HI/LO result registers
module mult_div_seq
  import md_pkg::*;
#(
  parameter int WIDTH = MD_ITER,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset_in,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  // Two guard bits keep the Booth accumulator exact for a zero-extended
  // full-range multiplicand and for the restoring trial subtract.
  localparam int AW = WIDTH + 2;

  md_state_t        state_q, state_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [AW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             q1_q, q1_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             busy_q, busy_d, done_q, done_d, div0_q, div0_d;
  logic             qneg_q, qneg_d, rneg_q, rneg_d;
  logic             corr_q, corr_d;

  logic             is_div, is_uns, last;
  logic [WIDTH-1:0] a_abs, b_abs, q_fix, r_fix;
  logic [AW-1:0]    bsum, diff;
  logic [WIDTH:0]   rem_shift;
  logic             dneg;

  assign is_div = (op == MD_DIV) || (op == MD_DIVU);
`ifdef MULT_DIV_UNSIGNED_EN
  assign is_uns = (op == MD_MULTU) || (op == MD_DIVU);
`else
  assign is_uns = 1'b0;
`endif

  md_sign_fix #(.WIDTH(WIDTH)) u_abs (
    .mag_q (a),
    .mag_r (b),
    .neg_q (!is_uns && a[WIDTH-1]),
    .neg_r (!is_uns && b[WIDTH-1]),
    .q     (a_abs),
    .r     (b_abs)
  );

  md_sign_fix #(.WIDTH(WIDTH)) u_fix (
    .mag_q (q_q),
    .mag_r (acc_q[WIDTH-1:0]),
    .neg_q (qneg_q),
    .neg_r (rneg_q),
    .q     (q_fix),
    .r     (r_fix)
  );

  assign last = (cnt_q == CNT_W'(WIDTH - 1));

  // Booth recoding of {q[0], q-1}: 01 adds, 10 subtracts the multiplicand.
  always_comb begin
    bsum = acc_q;
    case ({q_q[0], q1_q})
      2'b01:   bsum = acc_q + mcand_q;
      2'b10:   bsum = acc_q - mcand_q;
      default: bsum = acc_q;
    endcase
  end

  // Restoring step: remainder shifts in the next dividend bit from q.
  assign rem_shift = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
  assign diff      = {1'b0, rem_shift} - mcand_q;
  assign dneg      = diff[AW-1];

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    q_d     = q_q;
    q1_d    = q1_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    div0_d  = 1'b0;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    corr_d  = corr_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          cnt_d  = '0;
          acc_d  = '0;
          q1_d   = 1'b0;
          qneg_d = !is_uns && (a[WIDTH-1] ^ b[WIDTH-1]);
          rneg_d = !is_uns && a[WIDTH-1];
          // Booth sees b as signed; an unsigned b with its MSB set needs
          // one extra multiplicand added into HI at the end.
          corr_d = is_uns && !is_div && b[WIDTH-1];
          if (!is_div) begin
            mcand_d = is_uns ? {2'b00, a} : {{2{a[WIDTH-1]}}, a};
            q_d     = b;
            state_d = ST_MULT;
          end else if (b == '0) begin
            div0_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            mcand_d = {2'b00, b_abs};
            q_d     = a_abs;
            state_d = ST_DIV;
          end
        end
      end
      ST_MULT: begin
        acc_d = {bsum[AW-1], bsum[AW-1:1]};
        q_d   = {bsum[0], q_q[WIDTH-1:1]};
        q1_d  = q_q[0];
        cnt_d = cnt_q + CNT_W'(1);
        if (last) begin
          hi_d    = bsum[WIDTH:1] + (corr_q ? mcand_q[WIDTH-1:0] : '0);
          lo_d    = {bsum[0], q_q[WIDTH-1:1]};
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DIV: begin
        acc_d = dneg ? {1'b0, rem_shift} : diff;
        q_d   = {q_q[WIDTH-2:0], ~dneg};
        cnt_d = cnt_q + CNT_W'(1);
        if (last) state_d = ST_DIV_FIX;
      end
      ST_DIV_FIX: begin
        hi_d    = r_fix;
        lo_d    = q_fix;
        done_d  = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      mcand_q <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      div0_q  <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      corr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      div0_q  <= div0_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      corr_q  <= corr_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign div0 = div0_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_seq.sv
// tb/tb_mult_div_seq.sv - self-checking bench for mult_div_seq
module tb_mult_div_seq;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        reset_in = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done, div0;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  mult_div_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .clk      (clk),
    .reset_in (reset_in),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .div0     (div0),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Architectural result of one operation, from plain arithmetic.
  function automatic void model_calc(input logic [1:0] o, input logic [31:0] x,
                                     input logic [31:0] y,
                                     output logic [31:0] h, output logic [31:0] l);
    bit          uns;
    longint      sx, sy, p, qq, rr;
    logic [63:0] up;
`ifdef MULT_DIV_UNSIGNED_EN
    uns = o[1];
`else
    uns = 1'b0;
`endif
    sx = $signed(x);
    sy = $signed(y);
    if (!o[0]) begin
      if (uns) up = {32'b0, x} * {32'b0, y};
      else begin
        p  = sx * sy;
        up = p;
      end
      h = up[63:32];
      l = up[31:0];
    end else if (uns) begin
      l = x / y;
      h = x % y;
    end else begin
      qq = sx / sy;
      rr = sx % sy;
      l  = qq[31:0];
      h  = rr[31:0];
    end
  endfunction

  // Timing model: accepted start -> done 32 (mult) / 33 (div) edges later,
  // div-by-zero pulses immediately; DONE lasts one cycle.
  bit          m_busy = 0, m_done = 0, m_div0 = 0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  int          m_left = 0;

  always @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      m_busy = 0; m_done = 0; m_div0 = 0; m_hi = '0; m_lo = '0; m_left = 0;
    end else if (m_done || m_div0) begin
      m_done = 0; m_div0 = 0; m_busy = 0;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_hi = p_hi; m_lo = p_lo; m_done = 1;
      end
    end else if (start) begin
      m_busy = 1;
      if (op[0] && b == 32'd0) m_div0 = 1;
      else begin
        model_calc(op, a, b, p_hi, p_lo);
        m_left = op[0] ? 33 : 32;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_busy", {31'b0, busy}, {31'b0, m_busy});
      chk("cyc_done", {31'b0, done}, {31'b0, m_done});
      chk("cyc_div0", {31'b0, div0}, {31'b0, m_div0});
      chk("cyc_hi", hi, m_hi);
      chk("cyc_lo", lo, m_lo);
    end
  end

  // lat = edges after the start-sampling edge until done/div0 is visible.
  task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el,
                        input int elat, input bit ediv0, input int glitch_at);
    int lat = -1;
    int busy_cnt = 0;
    bit seen = 0;
    bit got_div0 = 0;
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (i == glitch_at) begin
        start = 1'b1; op = MD_DIV; a = 32'd100; b = 32'd0;
      end else start = 1'b0;
      if (busy) busy_cnt++;
      if (done || div0) begin
        seen = 1; lat = i; got_div0 = div0;
      end else @(negedge clk);
    end
    start = 1'b0;
    chk({nm, "_seen"}, {31'b0, seen}, 32'd1);
    chk({nm, "_lat"}, lat, elat);
    chk({nm, "_busycnt"}, busy_cnt, elat + 1);
    chk({nm, "_div0"}, {31'b0, got_div0}, {31'b0, ediv0});
    chk({nm, "_hi"}, hi, eh);
    chk({nm, "_lo"}, lo, el);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    #3;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_div0", {31'b0, div0}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_in = 1'b0;
    cmp_en = 1'b1;

    run_op("mul_7_m3",   MD_MULT, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 32, 0, -1);
    run_op("mul_max",    MD_MULT, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 32, 0, -1);
    run_op("mul_min",    MD_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 32, 0, -1);
    run_op("div_m7_2",   MD_DIV,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, 0, -1);
    run_op("div_by0",    MD_DIV,  32'h12345678, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 1, -1);
    run_op("div_ovf",    MD_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33, 0, -1);
    run_op("div_100_m7", MD_DIV,  32'd100,      32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2, 33, 0, -1);
    run_op("div_m100_7", MD_DIV,  32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFF2, 33, 0, -1);
    run_op("mul_glitch", MD_MULT, 32'd3,        32'd5,        32'h00000000, 32'h0000000F, 32, 0, 5);
`ifdef MULT_DIV_UNSIGNED_EN
    run_op("divu",       MD_DIVU,  32'hFFFFFFFF, 32'd2,        32'h00000001, 32'h7FFFFFFF, 33, 0, -1);
    run_op("multu",      MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 32, 0, -1);
`else
    run_op("divu",       MD_DIVU,  32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'h00000000, 33, 0, -1);
    run_op("multu",      MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 32, 0, -1);
`endif

    // Abort a multiply with an asynchronous reset ten cycles in.
    @(negedge clk);
    op = MD_MULT; a = 32'h0000ABCD; b = 32'h00001234; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2 reset_in = 1'b1;
    #1;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    @(negedge clk);
    reset_in = 1'b0;
    repeat (40) @(negedge clk);
    chk("abort_hi_after", hi, 32'd0);

    run_op("mul_post",   MD_MULT, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 32, 0, -1);

    @(negedge clk);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
